// File: rtl/bcd_display_sequencer_pkg.sv
// rtl/bcd_display_sequencer_pkg.sv - shared constants and state encoding for the BCD display sequencer
package bcd_display_sequencer_pkg;

    localparam int BCD_DIGITS      = 5;
    localparam int BCD_W           = 20;
    localparam int MAX_VAL_DEFAULT = 99999;

    // All-F nibbles render as blanks in display_controller.
    localparam logic [BCD_W-1:0] ERR_PATTERN = 20'hFFFFF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CONV   = 2'd1;
    localparam state_t ST_UPDATE = 2'd2;

endpackage

// File: rtl/dd_digit_adj.sv
// rtl/dd_digit_adj.sv - double-dabble digit correction cell: add 3 when nibble >= 5
module dd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bcd_display_sequencer.sv
// rtl/bcd_display_sequencer.sv - iterative binary-to-BCD converter and display update sequencer (optional LEAD_ZERO_BLANK_EN)
module bcd_display_sequencer
    import bcd_display_sequencer_pkg::*;
#(
    parameter int BIN_W   = 17,
    parameter int MAX_VAL = MAX_VAL_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  bin_valid,
    output logic                  bin_ready,
    input  logic [BIN_W-1:0]      bin_value,
    output logic [BCD_W-1:0]      bcd_value,
    output logic [BCD_DIGITS-1:0] digit_blank,
    output logic                  bcd_done,
    output logic                  overflow
);

    localparam int                 CNT_W    = $clog2(BIN_W);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BIN_W - 1);
    localparam logic [BIN_W-1:0]   MAX_BIN  = BIN_W'(MAX_VAL);

    state_t            state_q, state_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic [BCD_W-1:0]  bcd_value_q, bcd_value_d;
    logic              overflow_q, overflow_d;
    logic              bcd_done_q, bcd_done_d;

    logic [BCD_W-1:0]  acc_adj;
    logic [BCD_W-1:0]  acc_next;
    logic [BIN_W-1:0]  bin_next;
    logic              handshake;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        dd_digit_adj u_adj (
            .din  (acc_q[g*4 +: 4]),
            .dout (acc_adj[g*4 +: 4])
        );
    end

    assign acc_next  = {acc_adj[BCD_W-2:0], bin_q[BIN_W-1]};
    assign bin_next  = {bin_q[BIN_W-2:0], 1'b0};
    assign bin_ready = (state_q == ST_IDLE) && !clear;
    assign handshake = bin_valid && bin_ready;

`ifdef LEAD_ZERO_BLANK_EN
    logic [BCD_DIGITS-1:0] blank_q, blank_d;

    function automatic logic [BCD_DIGITS-1:0] lead_zero_mask(input logic [BCD_W-1:0] v);
        logic                  zero_run;
        logic [BCD_DIGITS-1:0] mask;
        zero_run = 1'b1;
        mask     = '0;
        // Digit 0 never blanks, so a zero value still shows a single "0".
        for (int i = BCD_DIGITS - 1; i >= 1; i--) begin
            zero_run = zero_run && (v[i*4 +: 4] == 4'd0);
            mask[i]  = zero_run;
        end
        return mask;
    endfunction

    assign digit_blank = blank_q;
`else
    assign digit_blank = '0;
`endif

    always_comb begin
        state_d     = state_q;
        bin_d       = bin_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        bcd_value_d = bcd_value_q;
        overflow_d  = overflow_q;
        bcd_done_d  = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        blank_d     = blank_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    bin_d   = bin_value;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = (bin_value > MAX_BIN);
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                acc_d = acc_next;
                bin_d = bin_next;
                cnt_d = cnt_q + CNT_W'(1);
                // A carry out of the top digit can only come from an out-of-range input.
                ovf_d = ovf_q | acc_adj[BCD_W-1];
                if (cnt_q == CNT_LAST) begin
                    // Outputs are published together on the last shift so the UPDATE
                    // cycle already shows the finished word alongside bcd_done.
                    state_d     = ST_UPDATE;
                    bcd_done_d  = 1'b1;
                    overflow_d  = ovf_d;
                    bcd_value_d = ovf_d ? ERR_PATTERN : acc_next;
`ifdef LEAD_ZERO_BLANK_EN
                    blank_d     = ovf_d ? '0 : lead_zero_mask(acc_next);
`endif
                end
            end
            ST_UPDATE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (clear) begin
            state_d     = ST_IDLE;
            bin_d       = '0;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            bcd_value_d = '0;
            overflow_d  = 1'b0;
            bcd_done_d  = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
            blank_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            bin_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            bcd_value_q <= '0;
            overflow_q  <= 1'b0;
            bcd_done_q  <= 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
            blank_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bin_q       <= bin_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            bcd_value_q <= bcd_value_d;
            overflow_q  <= overflow_d;
            bcd_done_q  <= bcd_done_d;
`ifdef LEAD_ZERO_BLANK_EN
            blank_q     <= blank_d;
`endif
        end
    end

    assign bcd_value = bcd_value_q;
    assign overflow  = overflow_q;
    assign bcd_done  = bcd_done_q;

endmodule

// File: tb/tb_bcd_display_sequencer.sv
// tb/tb_bcd_display_sequencer.sv - self-checking bench for bcd_display_sequencer against a decimal reference model
module tb_bcd_display_sequencer;

    localparam int BIN_W   = 17;
    localparam int MAX_VAL = 99999;
    localparam int LAT     = BIN_W + 1;

    logic              clk;
    logic              reset_n;
    logic              clear;
    logic              bin_valid;
    logic              bin_ready;
    logic [BIN_W-1:0]  bin_value;
    logic [19:0]       bcd_value;
    logic [4:0]        digit_blank;
    logic              bcd_done;
    logic              overflow;

    int total = 0;
    int bad   = 0;

    bcd_display_sequencer #(.BIN_W(BIN_W), .MAX_VAL(MAX_VAL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (clear),
        .bin_valid   (bin_valid),
        .bin_ready   (bin_ready),
        .bin_value   (bin_value),
        .bcd_value   (bcd_value),
        .digit_blank (digit_blank),
        .bcd_done    (bcd_done),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int          p;
        if (v > MAX_VAL) return 20'hFFFFF;
        r = '0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[i*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [4:0] ref_blank(input int v);
        logic [4:0] m;
        int         p;
        m = '0;
`ifdef LEAD_ZERO_BLANK_EN
        if (v <= MAX_VAL) begin
            p = 10;
            for (int i = 1; i < 5; i++) begin
                m[i] = (v < p);
                p = p * 10;
            end
        end
`else
        p = v;
`endif
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called right after the accepting clock edge.
    task automatic wait_result(input int v);
        int k;
        k = 0;
        #1 bin_valid = 1'b0;
        for (int i = 1; i <= 40 && k == 0; i++) begin
            @(negedge clk);
            if (i == 1) chk("busy_ready", 32'(bin_ready), 32'd0);
            if (bcd_done === 1'b1) k = i;
        end
        chk("latency", k, LAT);
        chk("bcd_value", 32'(bcd_value), 32'(ref_bcd(v)));
        chk("digit_blank", 32'(digit_blank), 32'(ref_blank(v)));
        chk("overflow", 32'(overflow), (v > MAX_VAL) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(bcd_done), 32'd0);
        chk("value_hold", 32'(bcd_value), 32'(ref_bcd(v)));
        chk("ready_after", 32'(bin_ready), 32'd1);
    endtask

    task automatic convert(input int v);
        @(negedge clk);
        chk("idle_ready", 32'(bin_ready), 32'd1);
        bin_valid = 1'b1;
        bin_value = BIN_W'(v);
        @(posedge clk);
        wait_result(v);
    endtask

    int q[$];
    int last_acc;
    int cyc;
    int dones;
    int exp_v;

    initial begin
        reset_n   = 1'b0;
        clear     = 1'b0;
        bin_valid = 1'b0;
        bin_value = '0;
        repeat (3) @(negedge clk);
        chk("rst_bcd", 32'(bcd_value), 32'd0);
        chk("rst_blank", 32'(digit_blank), 32'd0);
        chk("rst_done", 32'(bcd_done), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_ready", 32'(bin_ready), 32'd1);
        reset_n = 1'b1;

        convert(0);
        convert(12345);
        convert(42);
        convert(99999);
        convert(100000);
        convert(7);
        convert(131071);
        convert(9);
        convert(10);
        for (int n = 0; n < 16; n++) convert(int'($urandom_range(0, 131071)));
        for (int n = 0; n < 6; n++) convert(int'($urandom_range(99990, 100010)));

        // bin_valid held high with a new value every cycle
        last_acc = -1;
        for (cyc = 0; cyc < 120; cyc++) begin
            @(posedge clk);
            #1;
            bin_valid = 1'b1;
            bin_value = BIN_W'($urandom_range(0, 131071));
            @(negedge clk);
            if (bcd_done === 1'b1) begin
                if (q.size() == 0) chk("stream_extra_done", 32'd1, 32'd0);
                else begin
                    exp_v = q.pop_front();
                    chk("stream_bcd", 32'(bcd_value), 32'(ref_bcd(exp_v)));
                    chk("stream_ovf", 32'(overflow), (exp_v > MAX_VAL) ? 32'd1 : 32'd0);
                end
            end
            if (bin_ready === 1'b1) begin
                if (last_acc >= 0) chk("stream_spacing", cyc - last_acc, BIN_W + 2);
                last_acc = cyc;
                q.push_back(int'(bin_value));
            end
        end
        @(posedge clk);
        #1 bin_valid = 1'b0;
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            @(negedge clk);
            if (bcd_done === 1'b1) begin
                exp_v = q.pop_front();
                chk("drain_bcd", 32'(bcd_value), 32'(ref_bcd(exp_v)));
            end
        end
        chk("drain_empty", q.size(), 0);
        repeat (3) @(negedge clk);

        // clear mid-conversion
        convert(7);
        @(negedge clk);
        bin_valid = 1'b1;
        bin_value = BIN_W'(54321);
        @(posedge clk);
        #1 bin_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        chk("clear_ready", 32'(bin_ready), 32'd0);
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clear_bcd", 32'(bcd_value), 32'd0);
        chk("clear_done", 32'(bcd_done), 32'd0);
        chk("clear_ready_after", 32'(bin_ready), 32'd1);
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bcd_done === 1'b1) dones++;
        end
        chk("clear_no_done", dones, 0);

        // reset mid-conversion
        convert(100000);
        @(negedge clk);
        bin_valid = 1'b1;
        bin_value = BIN_W'(54321);
        @(posedge clk);
        #1 bin_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_bcd", 32'(bcd_value), 32'd0);
        chk("arst_ovf", 32'(overflow), 32'd0);
        chk("arst_done", 32'(bcd_done), 32'd0);
        chk("arst_blank", 32'(digit_blank), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bcd_done === 1'b1) dones++;
        end
        chk("arst_no_done", dones, 0);
        chk("arst_ready", 32'(bin_ready), 32'd1);

        // clear and bin_valid together: nothing accepted until clear drops
        @(negedge clk);
        clear     = 1'b1;
        bin_valid = 1'b1;
        bin_value = BIN_W'(321);
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clr_valid_not_taken", 32'(bin_ready), 32'd1);
        chk("clr_valid_bcd", 32'(bcd_value), 32'd0);
        @(posedge clk);
        wait_result(321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
